// File: rtl/four_way_grant_arbiter_pkg.sv
// Shared definitions for the four-way grant arbiter: FSM state encoding,
// requester index constants and the requester count.
package four_way_grant_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_A = 2'd0;
  localparam req_idx_t REQ_B = 2'd1;
  localparam req_idx_t REQ_C = 2'd2;
  localparam req_idx_t REQ_D = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/four_way_priority_select.sv
// Combinational winner selection: scans the request vector starting at
// 'start' and wrapping modulo four; the first set bit found wins.
module four_way_priority_select
  import four_way_grant_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           start,
  output req_idx_t           id,
  output logic               valid
);

  req_idx_t idx;

  // Walk the candidates from furthest to nearest so the nearest hit is
  // the last assignment and therefore the one that sticks.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    id    = REQ_A;
    valid = 1'b0;
    idx   = REQ_A;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) begin
        id    = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/four_way_grant_arbiter.sv
// Four-requester grant arbiter with a bounded hold time and a mandatory
// one-cycle idle turnaround between grants.
// Policy macro ARBITER_ROUND_ROBIN_EN: defined = round robin starting after
// the last winner (a first out of reset); undefined = fixed d > c > b > a.
module four_way_grant_arbiter
  import four_way_grant_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_id,
  output logic               grant_valid
);

  localparam int unsigned        CNT_W     = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t              state;
  logic [CNT_W-1:0]    hold_cnt;
  req_idx_t            start_idx;
  logic [NUM_REQ-1:0]  sel_req;
  req_idx_t            sel_id;
  logic                sel_valid;
  req_idx_t            win_id;
  logic                release_evt;
  logic                take_grant;

`ifdef ARBITER_ROUND_ROBIN_EN
  req_idx_t rr_ptr;

  // Search begins one past the previous winner.
  assign start_idx = rr_ptr + 2'd1;
  assign sel_req   = req;
  assign win_id    = sel_id;
`else
  // Fixed d > c > b > a: scanning the bit-reversed vector upward from 0
  // visits d first, so the found index maps back as REQ_D - id.
  assign start_idx = REQ_A;
  assign sel_req   = {req[REQ_A], req[REQ_B], req[REQ_C], req[REQ_D]};
  assign win_id    = REQ_D - sel_id;
`endif

  four_way_priority_select u_select (
    .req   (sel_req),
    .start (start_idx),
    .id    (sel_id),
    .valid (sel_valid)
  );

  assign take_grant  = (state == IDLE) && sel_valid;
  // Any of the three causes ends the grant; together they still act once.
  assign release_evt = done || !req[grant_id] || (hold_cnt == HOLD_LAST);

  // Grant FSM with registered outputs and the hold counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_id    <= REQ_A;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_grant) begin
            state       <= BUSY;
            hold_cnt    <= '0;
            grant       <= 4'b0001 << win_id;
            grant_id    <= win_id;
            grant_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (release_evt) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= REQ_A;
            grant_valid <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARBITER_ROUND_ROBIN_EN
  // Round-robin pointer remembers the most recent winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= REQ_D;
    end else if (take_grant) begin
      rr_ptr <= win_id;
    end
  end
`endif

endmodule

// File: tb/tb_four_way_grant_arbiter.sv
// Directed self-checking bench for four_way_grant_arbiter. Expectations
// follow the arbitration policy selected by ARBITER_ROUND_ROBIN_EN.
module tb_four_way_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done;
  logic [3:0] req;

  logic [3:0] grant,       grant_h1;
  logic [1:0] grant_id,    grant_id_h1;
  logic       grant_valid, grant_valid_h1;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef ARBITER_ROUND_ROBIN_EN
  int exp_seq [5] = '{0, 1, 2, 3, 0};
  int exp_after_rst = 0;
`else
  int exp_seq [5] = '{3, 3, 3, 3, 3};
  int exp_after_rst = 3;
`endif

  always #5 clk = ~clk;

  four_way_grant_arbiter #(.MAX_HOLD(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  four_way_grant_arbiter #(.MAX_HOLD(1)) u_dut_h1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant_h1),
    .grant_id    (grant_id_h1),
    .grant_valid (grant_valid_h1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Expected {valid, id, grant} for a grant to 'id', or all zero.
  function automatic logic [6:0] pack(input logic v, input int id);
    logic [1:0] i2;
    i2 = 2'(id);
    return v ? {1'b1, i2, 4'b0001 << i2} : 7'd0;
  endfunction

  task automatic expect_main(input string tag, input logic v, input int id);
    check(tag, {25'd0, grant_valid, grant_id, grant}, {25'd0, pack(v, id)});
  endtask

  task automatic expect_h1(input string tag, input logic v, input int id);
    check(tag, {25'd0, grant_valid_h1, grant_id_h1, grant_h1}, {25'd0, pack(v, id)});
  endtask

  // Advance one cycle; outputs are then stable for sampling and inputs
  // written afterwards take effect at the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    step();
    step();
    expect_main("reset_main", 1'b0, 0);
    expect_h1("reset_h1", 1'b0, 0);
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      step();
      expect_main($sformatf("idle%0d", i), 1'b0, 0);
    end

    // All requesting, done pulsed in each grant cycle.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_main($sformatf("seq_grant%0d", i), 1'b1, exp_seq[i]);
      done = 1'b1;
      step();
      expect_main($sformatf("seq_gap%0d", i), 1'b0, 0);
      done = 1'b0;
      if (i == 4) req = 4'b0000;
    end
    step();
    expect_main("seq_quiet", 1'b0, 0);

    // Hold limit: b alone, no done. MAX_HOLD=8 holds eight cycles,
    // MAX_HOLD=1 alternates grant and idle.
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_main($sformatf("hold%0d", i), (i != 8), 1);
      if (i < 4) expect_h1($sformatf("hold1_%0d", i), (i % 2 == 0), 1);
    end
    req = 4'b0000;
    step();
    expect_main("hold_drop", 1'b0, 0);

    // Owner c: other requests appear without effect, then c withdraws.
    req = 4'b0100;
    step();
    expect_main("c_grant", 1'b1, 2);
    req = 4'b1111;
    step();
    expect_main("c_stable", 1'b1, 2);
    req = 4'b1011;
    step();
    expect_main("c_withdraw", 1'b0, 0);
    req = 4'b0001;
    step();
    expect_main("a_after_c", 1'b1, 0);

    // Reset while b owns the grant.
    done = 1'b1;
    step();
    expect_main("a_done", 1'b0, 0);
    done = 1'b0;
    req  = 4'b0010;
    step();
    expect_main("b_grant", 1'b1, 1);
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    expect_main("rst_busy", 1'b0, 0);
    rst_n = 1'b1;
    step();
    expect_main("post_rst", 1'b1, exp_after_rst);
    done = 1'b1;
    req  = 4'b0000;
    step();
    expect_main("post_rst_gap", 1'b0, 0);
    done = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/four_way_grant_arbiter.md
FOUR_WAY_GRANT_ARBITER -- requirements
Module: four_way_grant_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one grant may be held (legal 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port req  input  4  request vector; bit 0 = requester a, bit 1 = b, bit 2 = c, bit 3 = d.
REQ-005 SHALL have port done  input  1  the current owner releases the grant this cycle.
REQ-006 SHALL have port grant  output  4  one-hot grant vector, all zero when no grant is held.
REQ-007 SHALL have port grant_id  output  2  encoded index of the granted requester; 0 when grant_valid=0.
REQ-008 SHALL have port grant_valid  output  1  high while any grant is held.

Function
REQ-009 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-010 IDLE with req!=0 SHALL select a winner and enter BUSY; grant, grant_id and grant_valid SHALL be registered and visible the next cycle (latency 1).
REQ-011 IDLE with req==0 SHALL stay in IDLE with all outputs zero.
REQ-012 BUSY SHALL hold grant stable until a release event: done=1, the owner's req bit=0, or the hold counter reaching MAX_HOLD-1.
REQ-013 A release event SHALL clear all outputs the next cycle and return to IDLE; the IDLE cycle is a mandatory one-cycle turnaround, so back-to-back grants are never adjacent.
REQ-014 The hold counter SHALL clear on grant, increment each BUSY cycle, and be sized $clog2(MAX_HOLD)+1 bits without wrap.
REQ-015 With MAX_HOLD=1, every grant SHALL last exactly one cycle.
REQ-016 Simultaneous release conditions SHALL count as a single release.
REQ-017 Requests that change while BUSY SHALL not affect grant, except the owner's own req bit as in REQ-012.
REQ-018 grant SHALL always be one-hot or zero and consistent with grant_id and grant_valid.

Reset
REQ-019 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE, the hold counter to 0, grant/grant_id/grant_valid to 0, and the round-robin pointer to 3.
REQ-020 Reset asserted during BUSY SHALL drop the grant on the following cycle without requiring done.
REQ-021 The first arbitration after reset SHALL occur no earlier than the first cycle with rst_n=1.

Configuration
REQ-022 Macro ARBITER_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-023 When ARBITER_ROUND_ROBIN_EN is defined:
- priority starts at last_id+1 and proceeds modulo 4.
- the pointer updates to the winner at each grant.
- after reset, the order is a > b > c > d.
REQ-024 When ARBITER_ROUND_ROBIN_EN is undefined:
- fixed priority d > c > b > a.
- no pointer register is built.

Structure
REQ-025 A shared package SHALL hold the FSM state enum (IDLE, BUSY), the requester index constants (A=0, B=1, C=2, D=3) and the requester count 4.
REQ-026 Winner selection SHALL be a combinational sub-module four_way_priority_select (inputs: req, start index; outputs: id, valid), instantiated once.

Verification
REQ-027 Reset release, req=4'b0000 for 5 cycles -> grant=0, grant_valid=0 every cycle.
REQ-028 Fixed build, req=4'b1111 held, done pulsed 1 cycle after each grant -> grant_id sequence 3,3,3,... each with one IDLE turnaround cycle between grants.
REQ-029 RR build, req=4'b1111 held, done pulsed after each grant -> grant_id 0,1,2,3,0, with grant_valid low for one cycle between grants.
REQ-030 MAX_HOLD=8, req=4'b0010 held, done=0 -> grant=4'b0010 for exactly 8 cycles, then 0 for 1 cycle, then re-granted.
REQ-031 While BUSY with owner c, deassert req[2] in cycle N -> grant=0 in cycle N+1; assert req[0] in cycle N+1 -> grant=4'b0001 in cycle N+2.
REQ-032 rst_n=0 for 1 cycle while BUSY with owner b -> outputs 0 the next cycle; RR pointer restarts with a first.
